branch_rs: RTL
==============

# branch_rs

Branch reservation station for the out-of-order core. Holds decoded conditional branches until both source operands are resolved, snooping two common data buses (ALU and load/store) for pending register tags. It then issues branches strictly in program order, one per cycle, into the branch execute unit through a registered issue port. The allocator writes into it on one side, and its issue register feeds the branch execute unit directly.

## Interface
- DEPTH, 4, number of entries; power of two, ≥2
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- rdy  in  1  global ready; 0 freezes all state
- alloc_en  in  1  allocator writes one branch this cycle
- alloc_op  in  `sinst_t  branch opcode (BEQ..BGEU)
- alloc_pc  in  `addr_t  branch PC
- alloc_offset  in  `word_t  sign-extended B-immediate
- alloc_tagx / alloc_tagy  in  `regtag_t  rs1/rs2 producer tag, `UNLOCKED if value valid
- alloc_datax / alloc_datay  in  `word_t  rs1/rs2 value, meaningful when tag `UNLOCKED
- rs_full  out  1  no free entry; combinational from count
- cdb0_en, cdb1_en  in  1  broadcast valid (ALU, LSB)
- cdb0_tag, cdb1_tag  in  `regtag_t  producing tag
- cdb0_data, cdb1_data  in  `word_t  produced value
- branch_busy_out  out  1  issue register holds a valid branch
- branch_op_out  out  `sinst_t
- pc_out  out  `addr_t
- offset_out  out  `word_t
- branch_tagx_out / branch_tagy_out  out  `regtag_t  always `UNLOCKED
- branch_datax_out / branch_datay_out  out  `word_t  resolved operands

## Operation
- Circular queue: head, tail pointers (log2 DEPTH bits, natural wrap), count (log2 DEPTH+1 bits). Entry = valid, op, pc, offset, tagx, datax, tagy, datay.
- Allocate: alloc_en && !rs_full && rdy → write at tail, tail+1, count+1. alloc_en while full is dropped; allocator must not do it.
- Allocation snoop: incoming tag matching an active CDB this cycle is stored as `UNLOCKED with the CDB data, so no wakeup is lost.
- Wakeup: every valid entry operand with tag == cdbN_tag while cdbN_en → data ← cdbN_data, tag ← `UNLOCKED. cdb0 wins if both match. A CDB tag of `UNLOCKED never matches.
- Issue: only the head entry may issue, when valid and both tags `UNLOCKED. On issue the entry is copied to the issue register, head+1, count−1, and the entry becomes invalid. A ready younger entry never bypasses a blocked head.
- Simultaneous allocate and issue: count unchanged. This is legal when full, because rs_full is taken from count before the edge, so alloc is still dropped.
- Issue register loads every edge. With no issue it clears: busy 0, data/pc/offset/op `ZERO, tags `UNLOCKED.
- rdy=0: queue, pointers and count hold; issue register clears so that the execute unit never sees a duplicate.

## Timing
- Reset (async, immediate): all entries invalid, head=tail=count=0, rs_full=0, branch_busy_out=0, op/pc/offset/data outputs `ZERO, tag outputs `UNLOCKED.
- Ready-at-allocation branch: written at edge N, issued at edge N+1, execute result at edge N+2.
- Branch waiting on a tag: broadcast in cycle K (captured at edge K), issue at edge K+1.
- Throughput: one issue per cycle when heads are ready back-to-back.
- Reset mid-operation drops all entries and any in-flight issue immediately.

## Configuration
- BRANCH_RS_CDB_BYPASS_EN defined: the head entry may issue in the same cycle its last pending operand appears on a CDB. The issue register takes cdbN_data directly (cdb0 priority), saving one cycle: broadcast in cycle K → issue at edge K.
- Undefined: the operand is captured first and issue happens at edge K+1. This is the timing given above.

## Test plan
- Ready branch: alloc BEQ pc=0x100, offset=0x20, datax=datay=5, tags `UNLOCKED → branch_busy_out=1 one cycle later with the same fields; busy=0 the following cycle.
- Wakeup: alloc BNE with tagx=3, datay=7; cdb1 broadcasts tag 3, data 9 two cycles later → issue with datax=9 at the next edge (same edge under BRANCH_RS_CDB_BYPASS_EN).
- Order: alloc A (tagx=2 pending), then B (ready) → nothing issues. cdb0 tag 2 → A issues, then B the next cycle.
- Full/wrap: DEPTH=4, fill 4 blocked entries → rs_full=1 and a 5th alloc is dropped. Release all, alloc 6 more → pointers wrap and issue order is preserved.
- Collision: cdb0 and cdb1 both carry tag 4 (data 1 vs 2) → the waiting operand gets 1. A cdb tag of `UNLOCKED wakes nothing.
- rdy=0 for 3 cycles with a ready head → branch_busy_out=0 and count unchanged. Issue resumes at the first edge with rdy=1. Assert rst mid-fill → all outputs return to reset values at once.

Source files
------------

// File: rtl/branch_rs.sv
// Branch reservation station: in-order issue of conditional branches after CDB wakeup.
// Optional BRANCH_RS_CDB_BYPASS_EN lets the head issue straight off a CDB broadcast.
package branch_rs_pkg;
  typedef logic [31:0] word_t;
  typedef logic [31:0] addr_t;
  typedef logic [4:0]  regtag_t;
  typedef logic [2:0]  sinst_t;

  localparam regtag_t UNLOCKED = 5'h1f;
  localparam word_t   ZERO     = 32'h0;

  localparam sinst_t BEQ  = 3'd0;
  localparam sinst_t BNE  = 3'd1;
  localparam sinst_t BLT  = 3'd4;
  localparam sinst_t BGE  = 3'd5;
  localparam sinst_t BLTU = 3'd6;
  localparam sinst_t BGEU = 3'd7;

  typedef struct packed {
    regtag_t tag;
    word_t   data;
  } opnd_t;

  typedef struct packed {
    logic   valid;
    sinst_t op;
    addr_t  pc;
    word_t  offset;
    opnd_t  x;
    opnd_t  y;
  } rs_entry_t;

  localparam opnd_t OPND_FREE = '{tag: UNLOCKED, data: ZERO};
  localparam rs_entry_t ENTRY_IDLE = '{
    valid: 1'b0, op: '0, pc: ZERO, offset: ZERO,
    x: OPND_FREE, y: OPND_FREE
  };
endpackage

module branch_rs
  import branch_rs_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    rdy,
  input  logic    alloc_en,
  input  sinst_t  alloc_op,
  input  addr_t   alloc_pc,
  input  word_t   alloc_offset,
  input  regtag_t alloc_tagx,
  input  regtag_t alloc_tagy,
  input  word_t   alloc_datax,
  input  word_t   alloc_datay,
  output logic    rs_full,
  input  logic    cdb0_en,
  input  logic    cdb1_en,
  input  regtag_t cdb0_tag,
  input  regtag_t cdb1_tag,
  input  word_t   cdb0_data,
  input  word_t   cdb1_data,
  output logic    branch_busy_out,
  output sinst_t  branch_op_out,
  output addr_t   pc_out,
  output word_t   offset_out,
  output regtag_t branch_tagx_out,
  output regtag_t branch_tagy_out,
  output word_t   branch_datax_out,
  output word_t   branch_datay_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  rs_entry_t      r_q [DEPTH];
  rs_entry_t      r_iss;
  logic [PW-1:0]  r_head;
  logic [PW-1:0]  r_tail;
  logic [CW-1:0]  r_count;

  rs_entry_t      w_wake [DEPTH];
  rs_entry_t      w_new;
  rs_entry_t      w_head;
  logic           w_full;
  logic           w_alloc;
  logic           w_issue;

  // A locked operand picks up a matching broadcast; cdb0 wins a tie.
  function automatic opnd_t snoop(input opnd_t o);
    snoop = o;
    if (o.tag != UNLOCKED) begin
      if (cdb0_en && cdb0_tag == o.tag)
        snoop = '{tag: UNLOCKED, data: cdb0_data};
      else if (cdb1_en && cdb1_tag == o.tag)
        snoop = '{tag: UNLOCKED, data: cdb1_data};
    end
  endfunction

  always_comb begin
    w_full  = (r_count == CW'(DEPTH));
    w_alloc = alloc_en && !w_full && rdy;
    for (int i = 0; i < DEPTH; i++) begin
      w_wake[i]   = r_q[i];
      w_wake[i].x = snoop(r_q[i].x);
      w_wake[i].y = snoop(r_q[i].y);
    end
    w_new        = ENTRY_IDLE;
    w_new.valid  = 1'b1;
    w_new.op     = alloc_op;
    w_new.pc     = alloc_pc;
    w_new.offset = alloc_offset;
    w_new.x      = snoop('{tag: alloc_tagx, data: alloc_datax});
    w_new.y      = snoop('{tag: alloc_tagy, data: alloc_datay});
`ifdef BRANCH_RS_CDB_BYPASS_EN
    w_head = w_wake[r_head];
`else
    w_head = r_q[r_head];
`endif
    w_issue = rdy && w_head.valid &&
              w_head.x.tag == UNLOCKED &&
              w_head.y.tag == UNLOCKED;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        r_q[i] <= ENTRY_IDLE;
      r_iss   <= ENTRY_IDLE;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      // Cleared whenever nothing issues, including while frozen.
      r_iss <= w_issue ? w_head : ENTRY_IDLE;
      if (rdy) begin
        for (int i = 0; i < DEPTH; i++)
          r_q[i] <= w_wake[i];
        if (w_issue)
          r_q[r_head].valid <= 1'b0;
        if (w_alloc)
          r_q[r_tail] <= w_new;
        r_head  <= r_head + PW'(w_issue);
        r_tail  <= r_tail + PW'(w_alloc);
        r_count <= r_count + CW'(w_alloc) - CW'(w_issue);
      end
    end
  end

  assign rs_full          = w_full;
  assign branch_busy_out  = r_iss.valid;
  assign branch_op_out    = r_iss.op;
  assign pc_out           = r_iss.pc;
  assign offset_out       = r_iss.offset;
  assign branch_tagx_out  = r_iss.x.tag;
  assign branch_tagy_out  = r_iss.y.tag;
  assign branch_datax_out = r_iss.x.data;
  assign branch_datay_out = r_iss.y.data;

endmodule
